// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER host driver/scorer.
package laser_pkg;

    localparam int NPTS   = 40;
    localparam int R2_MAX = 16;
    localparam int IDX_W  = 6;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        WAIT_DONE,
        SCORE,
        REPORT
    } state_t;

    function automatic coord_t abs_diff(coord_t a, coord_t b);
        return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
    endfunction

    // Squared distance: 4-bit deltas, 8-bit squares, 9-bit sum (cannot overflow).
    function automatic logic [8:0] dist2(point_t p, point_t c);
        coord_t     dx;
        coord_t     dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = abs_diff(p.x, c.x);
        dy = abs_diff(p.y, c.y);
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_host_if.sv
// System-side load/start/result signals and engine-side stream/result signals.
interface laser_host_if;
    import laser_pkg::*;

    logic              LD_EN;
    logic [IDX_W-1:0]  LD_ADDR;
    coord_t            LD_X;
    coord_t            LD_Y;
    logic              START;

    logic              L_RST;
    coord_t            X;
    coord_t            Y;
    coord_t            C1X;
    coord_t            C1Y;
    coord_t            C2X;
    coord_t            C2Y;
    logic              DONE;

    logic              BUSY;
    logic              RES_VALID;
    logic [IDX_W-1:0]  COVER;
    coord_t            R1X;
    coord_t            R1Y;
    coord_t            R2X;
    coord_t            R2Y;
    logic              ERR;

    modport slave (
        input  LD_EN, LD_ADDR, LD_X, LD_Y, START,
        input  C1X, C1Y, C2X, C2Y, DONE,
        output L_RST, X, Y,
        output BUSY, RES_VALID, COVER, R1X, R1Y, R2X, R2Y, ERR
    );

    modport master (
        output LD_EN, LD_ADDR, LD_X, LD_Y, START,
        output C1X, C1Y, C2X, C2Y, DONE,
        input  L_RST, X, Y,
        input  BUSY, RES_VALID, COVER, R1X, R1Y, R2X, R2Y, ERR
    );

endinterface

// File: rtl/laser_disk_chk.sv
// Combinational union test: is the point inside either radius-4 disk?
module laser_disk_chk
    import laser_pkg::*;
(
    input  point_t pt,
    input  point_t c1,
    input  point_t c2,
    output logic   hit
);

    logic [8:0] d1;
    logic [8:0] d2;

    assign d1  = dist2(pt, c1);
    assign d2  = dist2(pt, c2);
    assign hit = (d1 <= 9'(R2_MAX)) || (d2 <= 9'(R2_MAX));

endmodule

// File: rtl/laser_host.sv
// Host driver for the LASER engine: buffers 40 points, streams them into the
// engine, waits for DONE, captures both centres and scores their union coverage.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | engine held in reset; loads accepted; waiting for START
// ARM       | one cycle of margin before releasing the engine reset
// STREAM    | engine released; one point per cycle on X/Y, idx 0..39
// WAIT_DONE | last point held; waiting for DONE or timeout
// SCORE     | engine back in reset; one stored point scored per cycle
// REPORT    | publish COVER and pulse RES_VALID on the way out
module laser_host
    import laser_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    laser_host_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    point_t           pt_mem [NPTS];
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic [15:0]      timer_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cover_q;
    logic             l_rst_q;
    logic             res_valid_q;
    logic             err_q;
    coord_t           x_q;
    coord_t           y_q;
    point_t           r1_q;
    point_t           r2_q;

    logic             ld_we;
    logic             last_idx;
    logic             tmo_hit;
    logic             start_acc;
    logic             done_acc;
    logic             tmo_acc;
    logic             hit;
    point_t           score_pt;

    assign idx_nxt  = idx_q + IDX_W'(1);
    assign last_idx = (idx_q == LAST_IDX);
    assign tmo_hit  = (timer_q == TMO_LAST);
    assign ld_we    = (state_q == IDLE) && bus.LD_EN && (bus.LD_ADDR < IDX_W'(NPTS));
    // idx runs one past the end after the final score step; keep the read in range.
    assign score_pt = (idx_q < IDX_W'(NPTS)) ? pt_mem[idx_q] : '0;

    laser_disk_chk u_chk (
        .pt  (score_pt),
        .c1  (r1_q),
        .c2  (r2_q),
        .hit (hit)
    );

    // Point store: no reset so a data set survives RST.
    always_ff @(posedge CLK) begin
        if (ld_we) begin
            pt_mem[bus.LD_ADDR] <= {bus.LD_X, bus.LD_Y};
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and single-cycle action strobes.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        done_acc  = 1'b0;
        tmo_acc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d   = ARM;
                    start_acc = 1'b1;
                end
            end
            ARM: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (last_idx) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.DONE) begin
                    state_d  = SCORE;
                    done_acc = 1'b1;
                end else if (tmo_hit) begin
                    state_d = REPORT;
                    tmo_acc = 1'b1;
                end
            end
            SCORE: begin
                if (last_idx) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: stream index, timer, engine reset, captured centres and score.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q       <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            cover_q     <= '0;
            l_rst_q     <= 1'b1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
        end else begin
            res_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        err_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ARM: begin
                    l_rst_q <= 1'b0;
                    x_q     <= pt_mem[0].x;
                    y_q     <= pt_mem[0].y;
                    idx_q   <= '0;
                end
                STREAM: begin
                    if (last_idx) begin
                        timer_q <= '0;
                    end else begin
                        idx_q <= idx_nxt;
                        x_q   <= pt_mem[idx_nxt].x;
                        y_q   <= pt_mem[idx_nxt].y;
                    end
                end
                WAIT_DONE: begin
                    if (done_acc) begin
                        r1_q    <= {bus.C1X, bus.C1Y};
                        r2_q    <= {bus.C2X, bus.C2Y};
                        l_rst_q <= 1'b1;
                        idx_q   <= '0;
                    end else if (tmo_acc) begin
                        err_q   <= 1'b1;
                        l_rst_q <= 1'b1;
                        cover_q <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                SCORE: begin
                    if (hit) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                    idx_q <= idx_nxt;
                end
                REPORT: begin
                    // cnt_q was cleared at START, so an aborted run reports zero.
                    cover_q     <= cnt_q;
                    res_valid_q <= 1'b1;
                end
                default: begin
                    l_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.L_RST     = l_rst_q;
    assign bus.X         = x_q;
    assign bus.Y         = y_q;
    assign bus.BUSY      = (state_q != IDLE) || res_valid_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.COVER     = cover_q;
    assign bus.R1X       = r1_q.x;
    assign bus.R1Y       = r1_q.y;
    assign bus.R2X       = r2_q.x;
    assign bus.R2Y       = r2_q.y;
    assign bus.ERR       = err_q;

endmodule
